// File: rtl/combo_vector_checker.sv
// ============================================================================
// Module   : combo_vector_checker
// Purpose  : Walks all 8 {a,b,c} vectors and compares y with a golden table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module combo_vector_checker #(
  parameter logic [7:0]  EXPECTED = 8'b1110_1000,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_err_count,
  output logic [2:0] o_first_err_idx
);

  localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] C_LAST_IDX    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_err;
  logic [2:0] r_first;
  logic       r_first_vld;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic       w_mismatch;
  logic [3:0] w_err_next;

  assign w_mismatch = i_y ^ EXPECTED[r_idx];
  assign w_err_next = r_err + {3'b000, w_mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= 4'd0;
      r_err       <= 4'd0;
      r_first     <= 3'd0;
      r_first_vld <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_WAIT;
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_err       <= 4'd0;
            r_first     <= 3'd0;
            r_first_vld <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == C_SETTLE_LAST) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_first_vld) begin
            r_first     <= r_idx;
            r_first_vld <= 1'b1;
          end
          // The last vector is scored before DONE, so pass sees the final count.
          if (r_idx == C_LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 4'd0);
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_cnt   <= 4'd0;
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_a             = r_idx[2];
  assign o_b             = r_idx[1];
  assign o_c             = r_idx[0];
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_count     = r_err;
  assign o_first_err_idx = r_first;

endmodule

`default_nettype wire

// File: doc/combo_vector_checker.md
COMBO_VECTOR_CHECKER -- requirements
Module: combo_vector_checker

Interface
REQ-001 Parameter EXPECTED, default 8'b1110_1000, golden truth table; bit i is the expected y for vector i = {a,b,c}.
REQ-002 Parameter SETTLE, default 2, cycles each vector is held before y is sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-006 a, b, c  output  1 each  stimulus to the DUT, registered; {a,b,c} equals the vector index, a is the MSB.
REQ-007 y  input  1  DUT response, combinational function of a, b, c.
REQ-008 busy  output  1  high in WAIT and CHECK.
REQ-009 done  output  1  high in DONE.
REQ-010 pass  output  1  high in DONE when err_count is 0.
REQ-011 err_count  output  4  number of mismatching vectors in the current or last run, 0..8.
REQ-012 first_err_idx  output  3  index of the first mismatching vector; 0 when there is no error.

Function
REQ-013 FSM states: IDLE, WAIT, CHECK, DONE; 3-bit vector index idx; 4-bit settle counter cnt.
REQ-014 IDLE with start=1: go to WAIT; idx, cnt and err_count are set to 0; first_err_idx is set to 0 and the first-error flag is cleared.
REQ-015 WAIT: cnt increments every cycle; when cnt==SETTLE-1 the next state is CHECK.
REQ-016 CHECK lasts one cycle: y is sampled and compared with EXPECTED[idx].
REQ-017 On a mismatch in CHECK: err_count increments; if the first-error flag is clear, first_err_idx takes idx and the flag is set.
REQ-018 CHECK with idx<7: idx increments (a, b, c update on the same edge), cnt is set to 0, and the next state is WAIT.
REQ-019 CHECK with idx==7: go to DONE; idx does not wrap, so a, b, c hold 1,1,1.
REQ-020 Each vector occupies exactly SETTLE+1 cycles.
REQ-021 done rises exactly 8*(SETTLE+1) rising edges after the edge that sampled start; with the default SETTLE this is 24.
REQ-022 DONE holds done, pass, err_count and first_err_idx stable until start.
REQ-023 DONE with start=1: identical to REQ-014, i.e. a restart that clears all results.
REQ-024 start while busy is ignored and has no effect on the run.
REQ-025 A CHECK mismatch on idx 7 is counted before DONE is entered, so err_count may reach 8 with no overflow.
REQ-026 pass is 0 outside DONE.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, idx=0, cnt=0, a=b=c=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, and clears the first-error flag.
REQ-028 Reset asserted mid-run aborts the run immediately; no partial result is retained.
REQ-029 After rst_n deasserts, the block stays in IDLE until start.

Verification
REQ-030 Correct majority DUT, default parameters, one-cycle start pulse -> busy for 24 cycles, then done=1, pass=1, err_count=0, first_err_idx=0, a=b=c=1.
REQ-031 DUT output inverted -> err_count=8, first_err_idx=0, pass=0.
REQ-032 Majority DUT with a fault forced on vector 5 only -> err_count=1, first_err_idx=5, pass=0.
REQ-033 Faults on vectors 2 and 6 -> err_count=2, first_err_idx=2; a second start from DONE with the fault removed -> err_count=0, pass=1.
REQ-034 start pulsed in the 10th busy cycle -> no effect; done still rises at cycle 24.
REQ-035 rst_n low in the 13th busy cycle -> all outputs take their reset values asynchronously; after release the block idles with done=0 until start.
REQ-036 SETTLE=1 with a correct DUT -> done rises after 16 cycles, pass=1.
